mbl_resp_msg_buffer: RTL and testbench
======================================

# mbl_resp_msg_buffer

Store-and-forward message buffer on the response path of a message bus (mbl) node. It sits directly downstream of the node's `msg_resp_if` master port. It accepts multi-beat messages framed by `last` and holds each one until its final beat has arrived. It then releases whole messages, in order, to the next consumer. Partial messages therefore never stall the downstream arbiter.

## Interface
Parameters:
- `DATA_W`, 32: width of one message beat.
- `DEPTH`, 16: beat storage entries; must be a power of two and at least 2.
- `MSG_CNT_W`, `$clog2(DEPTH)+1`: width of the complete-message counter.

Ports:
- `clk`, input, 1: single clock; all logic is rising-edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `in_valid`, input, 1: upstream beat valid.
- `in_ready`, output, 1: buffer can accept a beat.
- `in_data`, input, DATA_W: upstream beat payload.
- `in_last`, input, 1: final beat of the message.
- `out_valid`, output, 1: downstream beat valid.
- `out_ready`, input, 1: downstream accepts the beat.
- `out_data`, output, DATA_W: downstream beat payload.
- `out_last`, output, 1: final beat of the released message.
- `level`, output, `$clog2(DEPTH)+1`: number of beats stored.
- `msg_count`, output, MSG_CNT_W: number of complete messages stored and not yet fully released.
- `err_oversize`, output, 1: sticky flag; a message filled the buffer before its last beat arrived.

## Operation
- Storage:
  - Circular RAM of DEPTH × (DATA_W+1) holding data plus the last bit.
  - Write and read pointers are `$clog2(DEPTH)+1` bits wide, with a wrap bit.
  - `level` = wr_ptr − rd_ptr, computed modulo 2^(`$clog2(DEPTH)+1`).
- Input handshake:
  - A beat is written when `in_valid && in_ready`.
  - `in_ready` = (`level` != DEPTH). It depends only on registered state.
- Message counting:
  - `msg_count` increments on a write with `in_last`=1.
  - It decrements on a read with `out_last`=1.
  - If both happen in the same cycle, it is unchanged.
- Output state machine:
  - OUT_IDLE: `out_valid`=0. Move to OUT_SEND when `msg_count`>0, or when `level`==DEPTH with `msg_count`==0 (oversize release).
  - OUT_SEND: `out_valid`=1 while `level`>0. `out_data`/`out_last` are the entry at rd_ptr. A read occurs when `out_valid && out_ready`.
  - A read with `out_last`=1 returns the machine to OUT_IDLE.
- Oversize handling:
  - Entering OUT_SEND through the oversize condition sets `err_oversize`.
  - That message is then streamed cut-through until its `last` beat.
  - During the stream, `out_valid` drops whenever `level`==0.
  - `err_oversize` clears only on reset.
- Simultaneous read and write:
  - Both occur; `level` is unchanged.
  - At `level`==DEPTH, `in_ready`=0 even if a read happens in the same cycle; there is no bypass.
- Zero-length messages do not exist: every message is at least one beat.

## Timing
- Reset values:
  - `in_ready`=1, `out_valid`=0, `out_data`=0, `out_last`=0, `level`=0, `msg_count`=0, `err_oversize`=0.
  - Pointers are 0; the state machine is in OUT_IDLE.
- Latency:
  - A last beat written at edge N makes `out_valid`=1 in the cycle after edge N+1.
  - That is one cycle in OUT_IDLE followed by the transition.
  - Minimum in-to-out latency for a single-beat message is 2 cycles.
- Throughput: once in OUT_SEND, one beat per cycle while `out_ready`=1.
- `out_data` must hold stable while `out_valid && !out_ready`.
- Back-to-back messages: after a last-beat read, at least one idle cycle in OUT_IDLE.
- Reset asserted mid-message:
  - All state clears immediately.
  - Partial and complete messages are discarded.
  - No output glitch beyond the asynchronous clear.

## Configuration
- `MBL_RESP_BUF_CUT_THROUGH_EN`:
  - Defined: OUT_IDLE moves to OUT_SEND whenever `level`>0, so beats are forwarded without waiting for the last beat. `err_oversize` is tied to 0. Minimum latency stays 2 cycles.
  - Undefined (default): store-and-forward behaviour as described above.

## Test plan
- Single beat: write 0xA5 with last=1 at cycle 0, `out_ready`=1 → `out_valid`=1 with 0xA5/last=1 at cycle 2; `msg_count` goes 0→1→0.
- Store-and-forward: write a 4-beat message with a 3-cycle gap before beat 3 → `out_valid` stays 0 until 2 cycles after the last-beat write, then 4 consecutive beats.
- Full and backpressure: `out_ready`=0, write 4 messages of 4 beats → `level`=16, `in_ready`=0; release all 16 beats in order with wrap, `msg_count` ending at 0.
- Oversize: DEPTH=16, write a 20-beat message with `out_ready`=1 → `err_oversize`=1 when `level`=16; all 20 beats emitted in order; flag stays 1.
- Concurrent read and write at `level`=8: `level` stays 8 and `msg_count` tracks last beats on both sides.
- Reset mid-message after 3 of 5 beats → all outputs return to reset values; a following 1-beat message passes with 2-cycle latency.

Source files
------------

// File: rtl/mbl_resp_msg_buffer.sv
// Store-and-forward response message buffer: holds multi-beat messages until their last beat arrives.
// Optional MBL_RESP_BUF_CUT_THROUGH_EN forwards beats as soon as any are stored.
module mbl_resp_msg_buffer #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 16,
    parameter int MSG_CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_last,
    output logic [$clog2(DEPTH):0]   level,
    output logic [MSG_CNT_W-1:0]     msg_count,
    output logic                     err_oversize
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] FULL_LVL = PW'(DEPTH);

    typedef enum logic {OUT_IDLE, OUT_SEND} out_state_t;

    logic [DATA_W:0]      mem [DEPTH];
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [PW-1:0]        lvl;
    logic [MSG_CNT_W-1:0] msg_cnt;
    logic [DATA_W:0]      rd_word;
    logic                 full;
    logic                 wr_en;
    logic                 rd_en;
    logic                 rd_last;
    out_state_t           state;
    out_state_t           state_nxt;

    assign lvl       = wr_ptr - rd_ptr;
    assign full      = (lvl == FULL_LVL);
    assign in_ready  = !full;
    assign wr_en     = in_valid && !full;
    assign rd_word   = mem[rd_ptr[AW-1:0]];
    assign rd_last   = rd_word[DATA_W];
    assign out_valid = (state == OUT_SEND) && (lvl != '0);
    assign rd_en     = out_valid && out_ready;
    // Gate the payload so the idle/reset value is zero instead of stale RAM contents.
    assign out_data  = out_valid ? rd_word[DATA_W-1:0] : '0;
    assign out_last  = out_valid && rd_last;
    assign level     = lvl;
    assign msg_count = msg_cnt;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= {in_last, in_data};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            msg_cnt <= '0;
            state   <= OUT_IDLE;
        end else begin
            state <= state_nxt;
            if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({wr_en && in_last, rd_en && rd_last})
                2'b10:   msg_cnt <= msg_cnt + MSG_CNT_W'(1);
                2'b01:   msg_cnt <= msg_cnt - MSG_CNT_W'(1);
                default: msg_cnt <= msg_cnt;
            endcase
        end
    end

`ifdef MBL_RESP_BUF_CUT_THROUGH_EN
    assign err_oversize = 1'b0;

    always_comb begin
        state_nxt = state;
        case (state)
            OUT_IDLE: if (lvl != '0) state_nxt = OUT_SEND;
            OUT_SEND: if (rd_en && rd_last) state_nxt = OUT_IDLE;
            default:  state_nxt = OUT_IDLE;
        endcase
    end
`else
    logic err_q;
    logic err_set;

    assign err_oversize = err_q;

    // A full buffer with no complete message can never finish its message; stream it out instead.
    always_comb begin
        state_nxt = state;
        err_set   = 1'b0;
        case (state)
            OUT_IDLE: begin
                if (msg_cnt != '0) begin
                    state_nxt = OUT_SEND;
                end else if (full) begin
                    state_nxt = OUT_SEND;
                    err_set   = 1'b1;
                end
            end
            OUT_SEND: if (rd_en && rd_last) state_nxt = OUT_IDLE;
            default:  state_nxt = OUT_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mbl_resp_msg_buffer.sv
// Self-checking bench for mbl_resp_msg_buffer (default store-and-forward build, DEPTH=16).
module tb_mbl_resp_msg_buffer;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_last = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic [4:0]        level;
    logic [4:0]        msg_count;
    logic              err_oversize;

    int total = 0;
    int bad   = 0;
    logic [32:0] sb[$];

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic [4:0]  exp_level;
        logic [4:0]  exp_msg;
    } vec_t;
    vec_t vecs[16];

    always #5 clk = ~clk;

    mbl_resp_msg_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .level(level), .msg_count(msg_count), .err_oversize(err_oversize)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Scoreboard: pop/compare on an output handshake, then push on an input handshake.
    always @(negedge clk) begin
        logic [32:0] e;
        if (reset_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_underflow: got %0h/%0b required nothing", out_data, out_last);
            end else begin
                e = sb.pop_front();
                chk("sb_data", 64'(out_data), 64'(e[31:0]));
                chk("sb_last", 64'(out_last), 64'(e[32]));
            end
        end
        if (reset_n && in_valid && in_ready) sb.push_back({in_last, in_data});
    end

    task automatic send_beat(input logic [31:0] d, input logic l);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            total++;
            bad++;
            $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_empty(input string name);
        int n = 0;
        while (!(level == 0 && msg_count == 0 && !out_valid) && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_level"}, 64'(level), 64'd0);
        chk({name, "_msg_count"}, 64'(msg_count), 64'd0);
        chk({name, "_sb_empty"}, 64'(sb.size()), 64'd0);
    endtask

    task automatic single_beat(input string name, input logic [31:0] d);
        send_beat(d, 1'b1);
        chk({name, "_msg_after_write"}, 64'(msg_count), 64'd1);
        chk({name, "_valid_cycle1"}, 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        chk({name, "_valid_cycle2"}, 64'(out_valid), 64'd1);
        chk({name, "_data"}, 64'(out_data), 64'(d));
        chk({name, "_last"}, 64'(out_last), 64'd1);
        @(posedge clk); #1;
        chk({name, "_msg_after_read"}, 64'(msg_count), 64'd0);
        chk({name, "_valid_after_read"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            vecs[i].data      = 32'hB000_0000 + 32'(i);
            vecs[i].last      = (i % 4 == 3);
            vecs[i].exp_level = 5'(i + 1);
            vecs[i].exp_msg   = 5'((i + 1) / 4);
        end

        // reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_msg_count", 64'(msg_count), 64'd0);
        chk("rst_err", 64'(err_oversize), 64'd0);
        reset_n   = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;

        // single-beat latency
        single_beat("single", 32'h0000_00A5);
        wait_empty("single");

        // store-and-forward with a gap before the last beat
        send_beat(32'hA000_0001, 1'b0);
        send_beat(32'hA000_0002, 1'b0);
        send_beat(32'hA000_0003, 1'b0);
        for (int g = 0; g < 3; g++) begin
            @(posedge clk); #1;
            chk("saf_gap_valid", 64'(out_valid), 64'd0);
        end
        send_beat(32'hA000_0004, 1'b1);
        chk("saf_valid_cycle1", 64'(out_valid), 64'd0);
        for (int b = 0; b < 4; b++) begin
            @(posedge clk); #1;
            chk("saf_stream_valid", 64'(out_valid), 64'd1);
        end
        @(posedge clk); #1;
        chk("saf_done_valid", 64'(out_valid), 64'd0);
        wait_empty("saf");

        // full buffer under backpressure, table-driven
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            send_beat(vecs[i].data, vecs[i].last);
            chk("full_level", 64'(level), 64'(vecs[i].exp_level));
            chk("full_msg_count", 64'(msg_count), 64'(vecs[i].exp_msg));
        end
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("full_out_valid", 64'(out_valid), 64'd1);
        chk("full_head", 64'(out_data), 64'(vecs[0].data));
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;
        in_last  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("full_no_write_level", 64'(level), 64'd16);
        chk("full_head_stable", 64'(out_data), 64'(vecs[0].data));
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        wait_empty("full");

        // concurrent read and write at level 8
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send_beat(32'hC100_0000 + 32'(i), (i == 7));
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("cc_level_start", 64'(level), 64'd8);
        chk("cc_valid_start", 64'(out_valid), 64'd1);
        for (int k = 1; k <= 8; k++) begin
            in_valid  = 1'b1;
            in_data   = 32'hC200_0000 + 32'(k);
            in_last   = (k == 4 || k == 8);
            out_ready = 1'b1;
            @(posedge clk); #1;
            chk("cc_level", 64'(level), 64'd8);
            chk("cc_msg_count", 64'(msg_count), (k < 4) ? 64'd1 : 64'd2);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        wait_empty("cc");

        // oversize message: 20 beats into 16 entries
        for (int i = 0; i < 16; i++) send_beat(32'hD000_0000 + 32'(i), 1'b0);
        @(negedge clk);
        chk("ovs_level_full", 64'(level), 64'd16);
        chk("ovs_in_ready", 64'(in_ready), 64'd0);
        chk("ovs_err_before", 64'(err_oversize), 64'd0);
        @(negedge clk);
        chk("ovs_err_set", 64'(err_oversize), 64'd1);
        chk("ovs_valid", 64'(out_valid), 64'd1);
        @(posedge clk); #1;
        for (int i = 16; i < 20; i++) send_beat(32'hD000_0000 + 32'(i), (i == 19));
        wait_empty("ovs");
        chk("ovs_err_sticky", 64'(err_oversize), 64'd1);

        // reset in the middle of a message
        for (int i = 0; i < 3; i++) send_beat(32'hE000_0000 + 32'(i), 1'b0);
        chk("mid_level", 64'(level), 64'd3);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_out_data", 64'(out_data), 64'd0);
        chk("mid_rst_out_last", 64'(out_last), 64'd0);
        chk("mid_rst_level", 64'(level), 64'd0);
        chk("mid_rst_msg_count", 64'(msg_count), 64'd0);
        chk("mid_rst_err", 64'(err_oversize), 64'd0);
        sb.delete();
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        single_beat("post_rst", 32'h0000_005A);
        wait_empty("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
